// File: rtl/video_sync_pattern.sv
// video_sync_pattern: hcnt/vcnt -> 2-stage registered hsync/vsync/de, x/y, frame_start and 24-bit test pattern r/g/b (mode: 0 bars, 1 ramp, 2 checker, 3 solid_rgb).
module video_sync_pattern #(
  parameter int   sync_h   = 44,
  parameter int   bp_h     = 148,
  parameter int   active_h = 1920,
  parameter int   total_h  = 2200,
  parameter int   sync_v   = 5,
  parameter int   bp_v     = 36,
  parameter int   active_v = 1080,
  parameter int   total_v  = 1125,
  parameter logic sync_pol = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] hcnt,
  input  logic [10:0] vcnt,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start
);
  localparam logic [11:0] hs_end = 12'(sync_h);
  localparam logic [11:0] ha_beg = 12'(sync_h + bp_h);
  localparam logic [11:0] ha_end = 12'(sync_h + bp_h + active_h);
  localparam logic [11:0] h_tot  = 12'(total_h);
  localparam logic [10:0] vs_end = 11'(sync_v);
  localparam logic [10:0] va_beg = 11'(sync_v + bp_v);
  localparam logic [10:0] va_end = 11'(sync_v + bp_v + active_v);
  localparam logic [10:0] v_tot  = 11'(total_v);
  localparam int          bar_w  = active_h / 8;
  logic        in_range, hs1_d, hs1_q, vs1_d, vs1_q, de1_d, de1_q, fs1_d, fs1_q;
  logic [10:0] x1_d, x1_q, y1_d, y1_q;
  logic [1:0]  mode_d, mode_q;
  logic [23:0] solid_d, solid_q;
  logic        hsync_d, hsync_q, vsync_d, vsync_q, de_d, de_q, fs_d, fs_q;
  logic [10:0] x_d, x_q, y_d, y_q;
  logic [23:0] rgb_d, rgb_q, bar_rgb, pat;
  logic [2:0]  bar;
  always_comb begin
    in_range = hcnt < h_tot && vcnt < v_tot;
    hs1_d    = in_range && hcnt < hs_end;
    vs1_d    = in_range && vcnt < vs_end;
    de1_d    = in_range && hcnt >= ha_beg && hcnt < ha_end && vcnt >= va_beg && vcnt < va_end;
    x1_d     = de1_d ? 11'(hcnt - ha_beg) : '0;
    y1_d     = de1_d ? vcnt - va_beg : '0;
    fs1_d    = hcnt == '0 && vcnt == '0;
    mode_d   = fs1_d ? mode : mode_q;
    solid_d  = fs1_d ? solid_rgb : solid_q;
  end
  // bar index = number of bar boundaries at or left of x; bar colours follow
  // R=~idx[1], G=~idx[2], B=~idx[0] for the standard white..black order
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) bar = bar + {2'b0, x1_q >= 11'(k * bar_w)};
    bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    pat     = mode_q == 2'd0 ? bar_rgb :
              mode_q == 2'd1 ? {3{x1_q[10:3]}} :
              mode_q == 2'd2 ? {24{x1_q[6] ^ y1_q[6]}} : solid_q;
    hsync_d = hs1_q ? sync_pol : ~sync_pol;
    vsync_d = vs1_q ? sync_pol : ~sync_pol;
    de_d    = de1_q;
    x_d     = x1_q;
    y_d     = y1_q;
    rgb_d   = de1_q ? pat : '0;
    fs_d    = fs1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      hsync_q <= ~sync_pol;
      vsync_q <= ~sync_pol;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de1_q   <= de1_d;
      fs1_q   <= fs1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign frame_start = fs_q;
endmodule

// File: tb/tb_video_sync_pattern.sv
// tb_video_sync_pattern: directed checks of sync decode, coordinates, patterns, mode capture and reset.
module tb_video_sync_pattern;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] x, y;
  logic [7:0]  r, g, b;
  int checks = 0;
  int passed = 0;
  int line_de = 0;
  always #5 clk = ~clk;
  video_sync_pattern dut (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y), .r(r), .g(g), .b(b),
    .frame_start(frame_start)
  );
  task automatic drive(input int h, input int v);
    hcnt = 12'(h);
    vcnt = 11'(v);
    @(posedge clk);
    #1;
  endtask
  task automatic probe(input int h, input int v);
    drive(h, v);
    drive(h, v);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(10 + i, 2);
    checks++;
    if ({hsync, vsync, de, frame_start} !== 4'b0000)
      $display("FAIL reset_ctrl got hs/vs/de/fs=%b required 0000", {hsync, vsync, de, frame_start});
    else passed++;
    checks++;
    if ({x, y, r, g, b} !== 46'd0)
      $display("FAIL reset_data got x=%0d y=%0d rgb=%h required 0 0 000000", x, y, {r, g, b});
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(2196 + i, 1124);
      else drive(i - 4, 0);
      checks++;
      if (frame_start !== (i == 5))
        $display("FAIL frame_start step %0d got %b required %b", i, frame_start, i == 5);
      else passed++;
    end
  endtask
  task automatic test_line;
    int hs_cnt = 0;
    int de_cnt = 0;
    int h;
    for (int i = 0; i <= 2200; i++) begin
      if (i < 2200) drive(i, 41);
      else drive(0, 42);
      if (i > 0) begin
        h = i - 1;
        hs_cnt += int'(hsync);
        de_cnt += int'(de);
        if (h == 191) begin
          checks++;
          if ({de, r, g, b} !== 25'd0) $display("FAIL h191 got de=%b rgb=%h required 0 000000", de, {r, g, b});
          else passed++;
        end
        if (h == 192) begin
          checks++;
          if ({de, x, y, r, g, b} !== {1'b1, 11'd0, 11'd0, 24'hFFFFFF})
            $display("FAIL h192 got de=%b x=%0d y=%0d rgb=%h required 1 0 0 ffffff", de, x, y, {r, g, b});
          else passed++;
        end
        if (h == 432) begin
          checks++;
          if ({de, x, r, g, b} !== {1'b1, 11'd240, 24'hFFFF00})
            $display("FAIL h432 got de=%b x=%0d rgb=%h required 1 240 ffff00", de, x, {r, g, b});
          else passed++;
        end
        if (h == 2111) begin
          checks++;
          if ({de, x, r, g, b} !== {1'b1, 11'd1919, 24'h000000})
            $display("FAIL h2111 got de=%b x=%0d rgb=%h required 1 1919 000000", de, x, {r, g, b});
          else passed++;
        end
        if (h == 2112) begin
          checks++;
          if ({de, r, g, b} !== 25'd0) $display("FAIL h2112 got de=%b rgb=%h required 0 000000", de, {r, g, b});
          else passed++;
        end
      end
    end
    line_de = de_cnt;
    checks++;
    if (hs_cnt != 44) $display("FAIL hsync_width got %0d required 44", hs_cnt);
    else passed++;
    checks++;
    if (de_cnt != 1920) $display("FAIL line_de got %0d required 1920", de_cnt);
    else passed++;
  endtask
  task automatic test_frame;
    int vs_cnt = 0;
    int de_lines = 0;
    int v;
    for (int i = 0; i <= 1125; i++) begin
      drive(192, i < 1125 ? i : 0);
      if (i > 0) begin
        v = i - 1;
        vs_cnt += int'(vsync);
        de_lines += int'(de);
        if (v == 40) begin
          checks++;
          if ({de, r, g, b} !== 25'd0) $display("FAIL v40 got de=%b rgb=%h required 0 000000", de, {r, g, b});
          else passed++;
        end
        if (v == 1120) begin
          checks++;
          if ({de, y, r, g, b} !== {1'b1, 11'd1079, 24'hFFFFFF})
            $display("FAIL v1120 got de=%b y=%0d rgb=%h required 1 1079 ffffff", de, y, {r, g, b});
          else passed++;
        end
        if (v == 1121) begin
          checks++;
          if ({de, r, g, b} !== 25'd0) $display("FAIL v1121 got de=%b rgb=%h required 0 000000", de, {r, g, b});
          else passed++;
        end
      end
    end
    checks++;
    if (vs_cnt != 5) $display("FAIL vsync_lines got %0d required 5", vs_cnt);
    else passed++;
    checks++;
    if (de_lines != 1080) $display("FAIL de_lines got %0d required 1080", de_lines);
    else passed++;
    checks++;
    if (de_lines * line_de != 2073600) $display("FAIL frame_de got %0d required 2073600", de_lines * line_de);
    else passed++;
    probe(2300, 2);
    checks++;
    if ({hsync, vsync, de} !== 3'b000) $display("FAIL out_of_range got hs/vs/de=%b required 000", {hsync, vsync, de});
    else passed++;
  endtask
  task automatic test_ramp;
    mode = 2'd1;
    drive(0, 0);
    mode = 2'd0;
    probe(192, 41);
    checks++;
    if ({de, y, r, g, b} !== {1'b1, 11'd0, 24'h000000})
      $display("FAIL ramp_x0 got de=%b y=%0d rgb=%h required 1 0 000000", de, y, {r, g, b});
    else passed++;
    probe(2111, 41);
    checks++;
    if ({de, x, r, g, b} !== {1'b1, 11'd1919, 24'hEFEFEF})
      $display("FAIL ramp_x1919 got de=%b x=%0d rgb=%h required 1 1919 efefef", de, x, {r, g, b});
    else passed++;
  endtask
  task automatic test_checker;
    mode = 2'd2;
    drive(0, 0);
    mode = 2'd0;
    probe(256, 41);
    checks++;
    if ({r, g, b} !== 24'hFFFFFF) $display("FAIL chk_64_0 got %h required ffffff", {r, g, b});
    else passed++;
    probe(256, 105);
    checks++;
    if ({r, g, b} !== 24'h000000) $display("FAIL chk_64_64 got %h required 000000", {r, g, b});
    else passed++;
    probe(192, 105);
    checks++;
    if ({r, g, b} !== 24'hFFFFFF) $display("FAIL chk_0_64 got %h required ffffff", {r, g, b});
    else passed++;
  endtask
  task automatic test_mode_change;
    mode = 2'd0;
    drive(0, 0);
    mode = 2'd3;
    solid_rgb = 24'h123456;
    probe(500, 500);
    checks++;
    if ({de, x, r, g, b} !== {1'b1, 11'd308, 24'hFFFF00})
      $display("FAIL mc_same_frame got de=%b x=%0d rgb=%h required 1 308 ffff00", de, x, {r, g, b});
    else passed++;
    probe(1000, 1000);
    checks++;
    if ({r, g, b} !== 24'h00FF00) $display("FAIL mc_bar3 got %h required 00ff00", {r, g, b});
    else passed++;
    drive(2199, 1124);
    drive(0, 0);
    solid_rgb = 24'hABCDEF;
    probe(192, 41);
    checks++;
    if ({de, r, g, b} !== {1'b1, 24'h123456}) $display("FAIL mc_first got de=%b rgb=%h required 1 123456", de, {r, g, b});
    else passed++;
    probe(2111, 1120);
    checks++;
    if ({de, r, g, b} !== {1'b1, 24'h123456}) $display("FAIL mc_last got de=%b rgb=%h required 1 123456", de, {r, g, b});
    else passed++;
  endtask
  task automatic test_reset_midframe;
    mode = 2'd0;
    probe(300, 300);
    checks++;
    if ({de, r, g, b} !== {1'b1, 24'h123456}) $display("FAIL rm_before got de=%b rgb=%h required 1 123456", de, {r, g, b});
    else passed++;
    reset = 1'b1;
    drive(301, 300);
    checks++;
    if ({de, x, r, g, b} !== 36'd0) $display("FAIL rm_clear got de=%b x=%0d rgb=%h required 0 0 000000", de, x, {r, g, b});
    else passed++;
    drive(302, 300);
    reset = 1'b0;
    drive(303, 300);
    checks++;
    if (de !== 1'b0) $display("FAIL rm_pipe_empty got de=%b required 0", de);
    else passed++;
    drive(304, 300);
    checks++;
    if ({de, x, r, g, b} !== {1'b1, 11'd111, 24'hFFFFFF})
      $display("FAIL rm_first_valid got de=%b x=%0d rgb=%h required 1 111 ffffff", de, x, {r, g, b});
    else passed++;
  endtask
  initial begin
    reset = 1'b1;
    hcnt = '0;
    vcnt = '0;
    mode = 2'd0;
    solid_rgb = 24'h0;
    test_reset;
    test_line;
    test_frame;
    test_ramp;
    test_checker;
    test_mode_change;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
